simeck_key_seq: RTL and testbench
=================================

# simeck_key_seq

Sequencer for the Simeck key-schedule datapath. It accepts a master key with a start/busy/done handshake and serialises the key into the 4-deep key register chain over four load cycles with `kctr` high. It then runs the schedule for `ROUNDS` cycles, driving the per-round constant `k` from the z0 LFSR sequence and flagging each valid round key for the round datapath.

## Interface
Parameters:
- `DATAW`, 16, word width; legal values 16 (Simeck32/64) and 24 (Simeck48/96).
- `ROUNDS`, 32, number of schedule rounds; 32 for DATAW=16, 36 for DATAW=24.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; accepted only in IDLE.
- `key`  in  4*DATAW  master key; must stay stable from accept until `done`.
- `busy`  out  1  high in LOAD and RUN.
- `done`  out  1  one-cycle pulse in DONE.
- `kctr`  out  1  key-chain load select; 1 = load `key_word`, 0 = feedback.
- `key_word`  out  DATAW  key word currently presented to the chain.
- `k`  out  DATAW  round constant.
- `rk_valid`  out  1  chain output is round key `rnd` this cycle.
- `rnd`  out  6  round index, 0..ROUNDS-1.
- `abort`  in  1  present only with SIMECK_KEY_SEQ_ABORT_EN.

## Operation
- States: IDLE, LOAD, RUN, DONE.
  - IDLE: `start`=1 moves to LOAD with the load counter `j` at 0. `start` is ignored in every other state.
  - LOAD: lasts 4 cycles, j=0..3. `kctr`=1 and `key_word` = `key[j*DATAW +: DATAW]`. After j=3, go to RUN with `rnd`=0 and the LFSR at 5'b11111.
  - RUN: lasts ROUNDS cycles. `kctr`=0, `rk_valid`=1, `rnd` increments each cycle. After `rnd`=ROUNDS-1, go to DONE.
  - DONE: one cycle, `done`=1, then IDLE.
- Round constant: `k` = {{(DATAW-2){1'b1}}, 1'b0, z}, which equals 2^DATAW-4 with z in the LSB.
  - z is the bit of the 5-bit LFSR sequence z0, period 31.
  - Bits for rounds 0..31: 11111010001001010110000111001101. Round 31 and later wrap to bit 0 (rounds 31..35 = 1,1,1,1,1).
  - The LFSR steps once per RUN cycle and holds in all other states.
- Outside RUN, `k` = all-ones-but-bit1 with z=1 (2^DATAW-3) and is don't-care to the datapath.
- `key_word` = 0 outside LOAD.
- `busy` = (state==LOAD || state==RUN).

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `kctr`=0, `key_word`=0, `rk_valid`=0, `rnd`=0, LFSR 5'b11111, `k`=2^DATAW-3.
- Reset is asynchronous and takes effect immediately, including mid-LOAD or mid-RUN. No `done` is produced for an interrupted run.
- Sequence for `start` sampled high at edge E:
  - LOAD occupies cycles E+1..E+4.
  - RUN occupies E+5..E+4+ROUNDS.
  - `done` is high in cycle E+5+ROUNDS.
  - The earliest next accept is at the edge ending the first IDLE cycle, E+6+ROUNDS.
- `start` held high continuously yields back-to-back runs separated by exactly one IDLE cycle.
- All outputs are registered. No combinational path exists from `start` or `key` to any output except `key_word`, which is a registered word select of `key`.
- `rnd` wraps to 0 on leaving RUN and never exceeds ROUNDS-1.

## Configuration
- `SIMECK_KEY_SEQ_ABORT_EN` defined:
  - Adds the `abort` input.
  - `abort`=1 sampled in LOAD or RUN forces IDLE at the next edge. `done` stays 0, `rk_valid` and `kctr` drop to 0, `rnd`=0, LFSR reloads 5'b11111.
  - `abort` in IDLE or DONE is ignored. If `abort` and `start` are both high in IDLE, `start` wins.
- Undefined: no `abort` port; every accepted run completes.

## Test plan
- Reset then idle: hold `reset`=0 for 3 cycles, release, keep `start`=0 for 10 cycles -> all outputs stay at reset values, `busy`=0.
- Single run, DATAW=16, key=64'h1918_1110_0908_0100:
  - `start` 1 cycle -> `kctr`=1 for 4 cycles with `key_word` 0100, 0908, 1110, 1918.
  - Then 32 cycles of `rk_valid`=1 with `rnd` 0..31 and `k` LSBs matching z0 (first five k = 16'hFFFD, last = 16'hFFFD).
  - `done` at cycle 37 after accept.
- DATAW=24, ROUNDS=36 -> `k` for rounds 31..35 = 24'hFFFFFD; `done` at cycle 41 after accept.
- `start` pulsed during LOAD and RUN -> ignored, timing unchanged. `start` held high -> runs repeat with exactly one IDLE cycle between `done` and the next LOAD.
- Async reset asserted mid-RUN at `rnd`=10 -> immediate return to reset values, no `done`. A new `start` produces a fresh run from `rnd`=0 with z restarting at 1.
- With SIMECK_KEY_SEQ_ABORT_EN, `abort` at `rnd`=5 -> IDLE next cycle, `done` never pulses, `rnd`=0. The next run's constants match a fresh run.

Source files
------------

// File: rtl/simeck_key_seq.sv
// Simeck key-schedule sequencer: loads the master key into the key chain, then runs the z0 round constants.
// Optional abort input enabled by defining SIMECK_KEY_SEQ_ABORT_EN.
module simeck_key_seq #(
    parameter int DATAW  = 16,
    parameter int ROUNDS = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [4*DATAW-1:0] key,
`ifdef SIMECK_KEY_SEQ_ABORT_EN
    input  logic               abort,
`endif
    output logic               busy,
    output logic               done,
    output logic               kctr,
    output logic [DATAW-1:0]   key_word,
    output logic [DATAW-1:0]   k,
    output logic               rk_valid,
    output logic [5:0]         rnd
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [4:0]       LFSR_INIT = 5'b11111;
    localparam logic [5:0]       RND_LAST  = 6'(ROUNDS - 1);
    localparam logic [DATAW-1:0] K_IDLE    = {{(DATAW-2){1'b1}}, 2'b01};

    function automatic logic [DATAW-1:0] k_of(input logic z);
        return {{(DATAW-2){1'b1}}, 1'b0, z};
    endfunction

    // z0 recurrence: s[t+5] = s[t] ^ s[t+1] ^ s[t+2] ^ s[t+4], output is bit 0
    function automatic logic [4:0] lfsr_step(input logic [4:0] s);
        return {s[0] ^ s[1] ^ s[2] ^ s[4], s[4:1]};
    endfunction

    state_t           state_q, state_d;
    logic [1:0]       j_q, j_d;
    logic [4:0]       lfsr_q, lfsr_d;
    logic [5:0]       rnd_q, rnd_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             kctr_q, kctr_d;
    logic             rk_valid_q, rk_valid_d;
    logic [DATAW-1:0] key_word_q, key_word_d;
    logic [DATAW-1:0] k_q, k_d;
    logic [DATAW-1:0] key_w [4];
    logic             abort_w;

`ifdef SIMECK_KEY_SEQ_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            key_w[i] = key[i*DATAW +: DATAW];
        end
    end

    always_comb begin
        state_d    = state_q;
        j_d        = j_q;
        lfsr_d     = lfsr_q;
        rnd_d      = rnd_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        kctr_d     = kctr_q;
        rk_valid_d = rk_valid_q;
        key_word_d = key_word_q;
        k_d        = k_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_LOAD;
                    j_d        = 2'd0;
                    busy_d     = 1'b1;
                    kctr_d     = 1'b1;
                    key_word_d = key_w[0];
                end
            end
            S_LOAD: begin
                if (j_q == 2'd3) begin
                    state_d    = S_RUN;
                    j_d        = 2'd0;
                    kctr_d     = 1'b0;
                    key_word_d = '0;
                    rk_valid_d = 1'b1;
                    rnd_d      = 6'd0;
                    // round 0 constant comes from the seed, lfsr then points at round 1
                    k_d        = k_of(LFSR_INIT[0]);
                    lfsr_d     = lfsr_step(LFSR_INIT);
                end else begin
                    j_d        = j_q + 2'd1;
                    key_word_d = key_w[j_q + 2'd1];
                end
            end
            S_RUN: begin
                if (rnd_q == RND_LAST) begin
                    state_d    = S_DONE;
                    done_d     = 1'b1;
                    busy_d     = 1'b0;
                    rk_valid_d = 1'b0;
                    rnd_d      = 6'd0;
                    k_d        = K_IDLE;
                    lfsr_d     = LFSR_INIT;
                end else begin
                    rnd_d  = rnd_q + 6'd1;
                    k_d    = k_of(lfsr_q[0]);
                    lfsr_d = lfsr_step(lfsr_q);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (abort_w && (state_q == S_LOAD || state_q == S_RUN)) begin
            state_d    = S_IDLE;
            j_d        = 2'd0;
            lfsr_d     = LFSR_INIT;
            rnd_d      = 6'd0;
            busy_d     = 1'b0;
            done_d     = 1'b0;
            kctr_d     = 1'b0;
            rk_valid_d = 1'b0;
            key_word_d = '0;
            k_d        = K_IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            j_q        <= 2'd0;
            lfsr_q     <= LFSR_INIT;
            rnd_q      <= 6'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            kctr_q     <= 1'b0;
            rk_valid_q <= 1'b0;
            key_word_q <= '0;
            k_q        <= K_IDLE;
        end else begin
            state_q    <= state_d;
            j_q        <= j_d;
            lfsr_q     <= lfsr_d;
            rnd_q      <= rnd_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            kctr_q     <= kctr_d;
            rk_valid_q <= rk_valid_d;
            key_word_q <= key_word_d;
            k_q        <= k_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign kctr     = kctr_q;
    assign key_word = key_word_q;
    assign k        = k_q;
    assign rk_valid = rk_valid_q;
    assign rnd      = rnd_q;

endmodule

// File: tb/tb_simeck_key_seq.sv
// Bench for simeck_key_seq: Simeck32/64 and Simeck48/96 instances against a bit-string z0 model.
// Abort scenario exercised when SIMECK_KEY_SEQ_ABORT_EN is defined.
module tb_simeck_key_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        start_a, start_b;
    logic [63:0] key_a;
    logic [95:0] key_b;
    logic        busy_a, done_a, kctr_a, rk_a;
    logic        busy_b, done_b, kctr_b, rk_b;
    logic [15:0] kw_a, k_a;
    logic [23:0] kw_b, k_b;
    logic [5:0]  rnd_a, rnd_b;
`ifdef SIMECK_KEY_SEQ_ABORT_EN
    logic        abort_a, abort_b;
`endif

    int vectors = 0;
    int miscompares = 0;

    // z0 bits for rounds 0..30, leftmost is round 0; period 31
    logic [30:0] z0_bits = 31'b1111101000100101011000011100110;

    simeck_key_seq #(.DATAW(16), .ROUNDS(32)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .key(key_a),
`ifdef SIMECK_KEY_SEQ_ABORT_EN
        .abort(abort_a),
`endif
        .busy(busy_a), .done(done_a), .kctr(kctr_a), .key_word(kw_a),
        .k(k_a), .rk_valid(rk_a), .rnd(rnd_a)
    );

    simeck_key_seq #(.DATAW(24), .ROUNDS(36)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .key(key_b),
`ifdef SIMECK_KEY_SEQ_ABORT_EN
        .abort(abort_b),
`endif
        .busy(busy_b), .done(done_b), .kctr(kctr_b), .key_word(kw_b),
        .k(k_b), .rk_valid(rk_b), .rnd(rnd_b)
    );

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        vectors++;
        assert (o === e) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    function automatic logic [31:0] exp_k(input int w, input int r, input bit in_run);
        logic [31:0] base;
        base = (32'd1 << w) - 32'd4;
        if (!in_run) return base + 32'd1;
        return base + 32'(z0_bits[30 - (r % 31)]);
    endfunction

    task automatic set_start(input int sel, input logic v);
        if (sel == 0) start_a = v;
        else start_b = v;
    endtask

    task automatic check_cycle(input int sel, input string tag,
                               input logic eb, input logic ed,
                               input logic ekc, input logic erk,
                               input logic [31:0] ekw, input logic [31:0] ek,
                               input logic [31:0] ernd);
        logic [31:0] ob, od, okc, ork, okw, ok, ornd;
        if (sel == 0) begin
            ob = 32'(busy_a); od = 32'(done_a); okc = 32'(kctr_a);
            ork = 32'(rk_a); okw = 32'(kw_a); ok = 32'(k_a); ornd = 32'(rnd_a);
        end else begin
            ob = 32'(busy_b); od = 32'(done_b); okc = 32'(kctr_b);
            ork = 32'(rk_b); okw = 32'(kw_b); ok = 32'(k_b); ornd = 32'(rnd_b);
        end
        chk({tag, ".busy"}, ob, 32'(eb));
        chk({tag, ".done"}, od, 32'(ed));
        chk({tag, ".kctr"}, okc, 32'(ekc));
        chk({tag, ".rk_valid"}, ork, 32'(erk));
        chk({tag, ".key_word"}, okw, ekw);
        chk({tag, ".k"}, ok, ek);
        chk({tag, ".rnd"}, ornd, ernd);
    endtask

    task automatic check_idle(input int sel, input string tag);
        int w;
        w = (sel == 0) ? 16 : 24;
        check_cycle(sel, tag, 0, 0, 0, 0, 0, exp_k(w, 0, 0), 0);
    endtask

    // Called at a negedge in IDLE; returns at the negedge of the first IDLE cycle after done.
    task automatic run_check(input int sel, input logic [95:0] kv, input bit hold, input bit noise);
        int r, w;
        logic [31:0] word;
        string tag;
        r = (sel == 0) ? 32 : 36;
        w = (sel == 0) ? 16 : 24;
        if (sel == 0) key_a = kv[63:0];
        else key_b = kv;
        set_start(sel, 1'b1);
        @(posedge clk);
        @(negedge clk);
        for (int n = 1; n <= 6 + r; n++) begin
            tag = $sformatf("d%0d_c%0d", sel, n);
            if (n <= 4) begin
                word = 32'(kv >> ((n - 1) * w)) & ((32'd1 << w) - 32'd1);
                check_cycle(sel, tag, 1, 0, 1, 0, word, exp_k(w, 0, 0), 0);
            end else if (n <= 4 + r) begin
                check_cycle(sel, tag, 1, 0, 0, 1, 0, exp_k(w, n - 5, 1), 32'(n - 5));
            end else if (n == 5 + r) begin
                check_cycle(sel, tag, 0, 1, 0, 0, 0, exp_k(w, 0, 0), 0);
            end else begin
                check_idle(sel, tag);
            end
            if (n < 6 + r) begin
                set_start(sel, hold ? 1'b1 : (noise ? 1'($urandom % 2) : 1'b0));
                @(negedge clk);
            end else begin
                set_start(sel, hold);
            end
        end
    endtask

    initial begin
        int dcount;
        reset = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        key_a = '0;
        key_b = '0;
`ifdef SIMECK_KEY_SEQ_ABORT_EN
        abort_a = 1'b0;
        abort_b = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check_idle(0, "rst_a");
        check_idle(1, "rst_b");
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_idle(0, $sformatf("idle_a%0d", i));
            check_idle(1, $sformatf("idle_b%0d", i));
        end

        run_check(0, 96'h0000_0000_1918_1110_0908_0100, 0, 0);
        run_check(1, {$urandom, $urandom, $urandom}, 0, 0);
        run_check(0, {32'd0, $urandom, $urandom}, 0, 1);
        run_check(1, {$urandom, $urandom, $urandom}, 0, 1);

        run_check(0, {32'd0, $urandom, $urandom}, 1, 0);
        run_check(0, {32'd0, $urandom, $urandom}, 1, 0);
        run_check(0, {32'd0, $urandom, $urandom}, 0, 0);
        run_check(1, {$urandom, $urandom, $urandom}, 1, 0);
        run_check(1, {$urandom, $urandom, $urandom}, 0, 0);

        // asynchronous reset in the middle of round 10
        key_a = {$urandom, $urandom};
        start_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_a = 1'b0;
        repeat (14) @(negedge clk);
        chk("pre_rst.rnd", 32'(rnd_a), 32'd10);
        #2 reset = 1'b0;
        #1 check_idle(0, "async_rst");
        @(negedge clk);
        check_idle(0, "held_rst");
        reset = 1'b1;
        dcount = 0;
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            if (done_a) dcount++;
        end
        chk("rst_nodone", 32'(dcount), 32'd0);
        run_check(0, {32'd0, $urandom, $urandom}, 0, 0);

`ifdef SIMECK_KEY_SEQ_ABORT_EN
        key_a = {$urandom, $urandom};
        start_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_a = 1'b0;
        repeat (9) @(negedge clk);
        chk("pre_abort.rnd", 32'(rnd_a), 32'd5);
        abort_a = 1'b1;
        @(negedge clk);
        abort_a = 1'b0;
        check_idle(0, "abort");
        dcount = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done_a || busy_a) dcount++;
        end
        chk("abort_quiet", 32'(dcount), 32'd0);
        start_a = 1'b1;
        abort_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_a = 1'b0;
        abort_a = 1'b0;
        chk("start_wins.kctr", 32'(kctr_a), 32'd1);
        repeat (40) @(negedge clk);
        check_idle(0, "after_sw");
        run_check(0, {32'd0, $urandom, $urandom}, 0, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
